// File: rtl/ofm_drain.sv
// ofm_drain: drains packed output-feature-map words from out_buf port b after a
// layer completes and streams each 64-bit word as four 16-bit results over a
// valid/ready interface.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 one-cycle pulse that begins a drain (from layer_ready)
//   base_addr, num_words  first word address and word count, sampled on start
//   ram_addr, ram_rden    out_buf port-b address / read enable
//   ram_q                 out_buf port-b read data, RD_LAT cycles after ram_rden
//   out_data, out_valid   unpacked result stream (lane 0 = bits [63:48] first)
//   out_ready             downstream accept
//   busy                  drain in progress
//   done                  one-cycle pulse after the final lane is accepted
module ofm_drain #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned LANE_W = 16;
    localparam int unsigned WAIT_W = 2;
    localparam int unsigned CMP_W  = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   num_q, num_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]          lane_q, lane_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [DATA_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
    logic                ram_rden_q, ram_rden_d;
    logic [LANE_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    // Lane 0 is the most significant 16 bits, matching the write-side packing.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [DATA_W-1:0] w,
                                                   input logic [1:0]        l);
        logic [LANE_W-1:0] r;
        case (l)
            2'd0:    r = w[LANE_W*3 +: LANE_W];
            2'd1:    r = w[LANE_W*2 +: LANE_W];
            2'd2:    r = w[LANE_W*1 +: LANE_W];
            default: r = w[0 +: LANE_W];
        endcase
        return r;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            num_q       <= '0;
            word_cnt_q  <= '0;
            lane_q      <= '0;
            wait_q      <= '0;
            word_q      <= '0;
            ram_addr_q  <= '0;
            ram_rden_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            num_q       <= num_d;
            word_cnt_q  <= word_cnt_d;
            lane_q      <= lane_d;
            wait_q      <= wait_d;
            word_q      <= word_d;
            ram_addr_q  <= ram_addr_d;
            ram_rden_q  <= ram_rden_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state and next-output logic; outputs are computed for the next state.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        num_d       = num_q;
        word_cnt_d  = word_cnt_q;
        lane_d      = lane_q;
        wait_d      = wait_q;
        word_d      = word_q;
        ram_addr_d  = ram_addr_q;
        ram_rden_d  = 1'b0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d     = base_addr;
                    num_d      = num_words;
                    word_cnt_d = '0;
                    if (num_words == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_READ;
                        ram_rden_d = 1'b1;
                        ram_addr_d = base_addr;
                    end
                end
            end
            S_READ: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_W'(RD_LAT - 1)) begin
                    word_d      = ram_q;
                    lane_d      = 2'd0;
                    out_valid_d = 1'b1;
                    out_data_d  = lane_sel(ram_q, 2'd0);
                    state_d     = S_EMIT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (lane_q != 2'd3) begin
                        lane_d     = lane_q + 2'd1;
                        out_data_d = lane_sel(word_q, lane_q + 2'd1);
                    end else begin
                        out_valid_d = 1'b0;
                        word_cnt_d  = word_cnt_q + ADDR_W'(1);
                        // Widened compare so a full-range count cannot wrap.
                        if (CMP_W'(word_cnt_q) + CMP_W'(1) == CMP_W'(num_q)) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d    = S_READ;
                            ram_rden_d = 1'b1;
                            ram_addr_d = base_q + word_cnt_q + ADDR_W'(1);
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy stays up through the done pulse and drops the cycle after.
        busy_d = (state_d != S_IDLE);
    end

    assign ram_addr  = ram_addr_q;
    assign ram_rden  = ram_rden_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/ofm_drain.md
Name: ofm_drain

Overview:
- Read-side counterpart of the psum write path (data_pack into out_buf port a).
- After a layer completes, it reads packed 64-bit output-feature-map words from out_buf port b and unpacks each word into four 16-bit results.
- Results leave as a valid/ready stream toward the host/DMA side.
- Sits beside out_buf; shares port b with the read-modify-write path, which is idle once layer_ready has fired.

Parameters:
ADDR_W, 16, width of the out_buf address and word count
DATA_W, 64, packed word width; fixed at 4 lanes x 16 bits
RD_LAT, 1, out_buf port-b read latency in cycles; legal values are 1 and 2

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse (driven from layer_ready) that begins a drain
base_addr  in  ADDR_W  first out_buf word address; sampled on start
num_words  in  ADDR_W  number of 64-bit words to drain; sampled on start
ram_addr  out  ADDR_W  out_buf port-b address (drives out_addr_2)
ram_rden  out  1  out_buf port-b read enable
ram_q  in  DATA_W  out_buf port-b read data
out_data  out  16  unpacked result lane
out_valid  out  1  out_data is valid
out_ready  in  1  downstream accepts out_data
busy  out  1  drain in progress
done  out  1  one-cycle pulse after the final lane is accepted

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - ram_addr=0, ram_rden=0, out_data=0, out_valid=0, busy=0, done=0.
  - Word register, lane counter and word counter all cleared.
- Reset mid-drain: the drain is abandoned immediately. After release the block sits in IDLE and waits for a new start; there is no resume.
- States: IDLE, READ, WAIT, EMIT, DONE. All outputs are registered.
- IDLE:
  - busy=0.
  - start=1 latches base_addr and num_words and clears the word counter.
  - If num_words=0, go to DONE (no RAM access). Otherwise go to READ.
- READ:
  - Exactly one cycle: ram_rden=1, ram_addr=base_addr+word_cnt (mod 2^ADDR_W, so addresses wrap).
  - Next state WAIT.
- WAIT:
  - RD_LAT cycles with ram_rden=0.
  - On the final WAIT edge, capture ram_q into the word register, set lane=0, assert out_valid, and go to EMIT.
- EMIT:
  - Lane order: lane 0=[63:48], lane 1=[47:32], lane 2=[31:16], lane 3=[15:0]. This matches the ifm_0..ifm_3 packing.
  - Handshake: out_data/out_valid stay stable while out_valid=1 and out_ready=0. A beat transfers on an edge where both are 1. out_ready is allowed to be high before out_valid.
  - After a transfer on lanes 0-2: lane increments and the next lane is presented in the following cycle, with no bubble.
  - Transfer on lane 3:
    - out_valid drops and word_cnt increments.
    - If word_cnt+1 == num_words, go to DONE; otherwise go to READ.
- DONE: done=1 for one cycle, busy=0 from the next cycle, then return to IDLE.
- busy=1 in READ, WAIT and EMIT.
- start while busy or in DONE is ignored, and base/count are not resampled.
- Timing with out_ready tied to 1 and RD_LAT=1 (start sampled at edge 0):
  - READ in cycle 1; first out_valid in cycle 3.
  - 6 cycles per word (1 READ + RD_LAT WAIT + 4 EMIT).
  - done appears in the cycle after the last beat.
- num_words=2^ADDR_W-1 is legal. The word counter is ADDR_W bits and must not overflow before the compare.

Test Plan:
- Single word, RD_LAT=1, out_ready=1: RAM[0x10]=0x1111_2222_3333_4444; start, base=0x10, num=1 -> rden at cycle 1 with addr 0x10; out_data 0x1111, 0x2222, 0x3333, 0x4444 in cycles 3-6; done in cycle 7; busy low from cycle 8.
- Backpressure: same word, out_ready=0 for cycles 3-5, then 1 -> 0x1111 held stable through cycle 5; no lane is skipped or duplicated; done arrives 3 cycles later than in the single-word case.
- Multi-word with wrap, RD_LAT=2: base=0xFFFE, num=3 -> rden addresses 0xFFFE, 0xFFFF, 0x0000; 12 beats in order; 7 cycles per word with ready=1.
- Zero count: start with num=0 -> ram_rden never asserts, out_valid never asserts, done pulses in cycle 1.
- start while busy: second start (base=0x40) during EMIT of a 2-word drain -> ignored; addresses stay base, base+1; exactly one done pulse.
- Async reset mid-EMIT: assert rst between clock edges during lane 1 -> out_valid, busy and ram_rden go to 0 immediately; after release there is no activity until a new start, which then drains correctly.
